// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants, FSM encoding and pointer helper for the shared-adder arbiter.
package adder_share_arbiter_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Round-robin successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the shared adder.
interface adder_share_arbiter_if;
  import adder_share_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_sum;
  logic                     resp_carry;
  logic [ID_W-1:0]          resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_carry, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_carry, resp_id
  );
endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping, gated by en.
module rr_arbiter
  import adder_share_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Scan upward from the pointer and grant the first valid requester.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered adder shared round-robin between NUM_REQ requesters.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  adder_share_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              run_q, run_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               slot_free_c;
  logic               grant_c;
  logic [WIDTH-1:0]   op_a_c, op_b_c;
  logic [WIDTH:0]     add_c;

  // run_q keeps grants off until the first edge after reset release.
  assign slot_free_c = run_q && ((state_q == ST_EMPTY) || bus.resp_ready);

  rr_arbiter u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .en     (slot_free_c),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign grant_c = |gnt;

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_a_c = op_a_c | bus.req_a[i*WIDTH +: WIDTH];
        op_b_c = op_b_c | bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign add_c = {1'b0, op_a_c} + {1'b0, op_b_c};

  // Next state, pointer advance and result capture.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    run_d   = 1'b1;
    case (state_q)
      ST_EMPTY: if (grant_c) state_d = ST_FULL;
      ST_FULL:  if (bus.resp_ready && !grant_c) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (grant_c) begin
      {carry_d, sum_d} = add_c;
      id_d             = gnt_id;
      ptr_d            = rr_next(gnt_id);
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      run_q   <= run_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = (state_q == ST_FULL);
  assign bus.resp_sum   = sum_q;
  assign bus.resp_carry = carry_q;
  assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: random and directed traffic.
module tb_adder_share_arbiter;
  import adder_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  adder_share_arbiter_if bus();

  adder_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [NUM_REQ-1:0] rv;
  logic [WIDTH-1:0]   ra [NUM_REQ];
  logic [WIDTH-1:0]   rb [NUM_REQ];
  logic               rr;

  assign bus.req_valid  = rv;
  assign bus.resp_ready = rr;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign bus.req_a[g*WIDTH +: WIDTH] = ra[g];
    assign bus.req_b[g*WIDTH +: WIDTH] = rb[g];
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } exp_t;

  exp_t sb[$];
  bit   exp_valid;
  int   last_ptr;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: grant goes to the first valid requester after the last one served.
  always @(negedge clk) begin : monitor
    int   gi;
    int   j;
    logic [NUM_REQ-1:0] er;
    exp_t e;
    if (!rst_n) begin
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      sb.delete();
      exp_valid = 1'b0;
      last_ptr  = 0;
    end else begin
      gi = -1;
      if (!exp_valid || rr) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (last_ptr + k) % NUM_REQ;
          if (gi < 0 && rv[j]) gi = j;
        end
      end
      er = '0;
      if (gi >= 0) er[gi] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual=valid expected=idle at %0t", $time);
        end else begin
          e = sb[0];
          chk("resp_sum", 64'(bus.resp_sum), 64'(e.sum));
          chk("resp_carry", 64'(bus.resp_carry), 64'(e.carry));
          chk("resp_id", 64'(bus.resp_id), 64'(e.id));
          if (rr) void'(sb.pop_front());
        end
      end
      if (gi >= 0) begin
        e.id = ID_W'(gi);
        {e.carry, e.sum} = {1'b0, ra[gi]} + {1'b0, rb[gi]};
        sb.push_back(e);
        exp_valid = 1'b1;
        last_ptr  = (gi + 1) % NUM_REQ;
      end else if (exp_valid && rr) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Present a request unless one is already pending on that port.
  task automatic raise(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (!rv[i]) begin
      ra[i] = a;
      rb[i] = b;
      rv[i] = 1'b1;
    end
  endtask

  // One clock; drop requests that were accepted on this edge.
  task automatic step();
    logic [NUM_REQ-1:0] took;
    @(negedge clk);
    took = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (took[i]) rv[i] = 1'b0;
  endtask

  task automatic chk_resp(input string name, input logic [WIDTH-1:0] s, input logic c, input logic [ID_W-1:0] id);
    chk({name, "_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({name, "_sum"}, 64'(bus.resp_sum), 64'(s));
    chk({name, "_carry"}, 64'(bus.resp_carry), 64'(c));
    chk({name, "_id"}, 64'(bus.resp_id), 64'(id));
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rv = '0;
    rr = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #21 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single request
    raise(0, 32'h0040_0000, 32'd4);
    step();
    chk_resp("single", 32'h0040_0004, 1'b0, 2'd0);
    repeat (2) step();

    // All requesters continuously valid
    repeat (8) begin
      for (int i = 0; i < NUM_REQ; i++) raise(i, $urandom, $urandom);
      step();
    end

    // Backpressure then resume
    rr = 1'b0;
    raise(1, $urandom, $urandom);
    raise(2, $urandom, $urandom);
    repeat (3) step();
    rr = 1'b1;
    repeat (4) step();

    // Wrap and carry, branch target with negative offset
    raise(0, 32'hFFFF_FFFC, 32'd8);
    step();
    chk_resp("wrap", 32'h0000_0004, 1'b1, 2'd0);
    raise(1, 32'h0000_1004, 32'hFFFF_FFF0);
    step();
    chk_resp("branch", 32'h0000_0FF4, 1'b1, 2'd1);

    // Pass-through with no bubble
    raise(0, 32'h0000_0100, 32'h0000_0004);
    step();
    chk_resp("pt_first", 32'h0000_0104, 1'b0, 2'd0);
    raise(2, 32'h0000_0010, 32'h0000_0020);
    step();
    chk_resp("pt_second", 32'h0000_0030, 1'b0, 2'd2);
    repeat (2) step();

    // Asynchronous reset with a held result and a pending request
    rr = 1'b0;
    raise(0, 32'd5, 32'd6);
    step();
    raise(1, 32'd7, 32'd8);
    step();
    chk_resp("pre_rst", 32'd11, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("async_rst_sum", 64'(bus.resp_sum), 64'd0);
    chk("async_rst_carry", 64'(bus.resp_carry), 64'd0);
    chk("async_rst_id", 64'(bus.resp_id), 64'd0);
    chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
    rv = '0;
    rr = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(bus.resp_valid), 64'd0);

    // Randomized traffic with random backpressure
    repeat (600) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(2) == 0) begin
          a = $urandom;
          b = $urandom;
          if ($urandom_range(3) == 0) a = 32'hFFFF_FF00 | WIDTH'($urandom_range(255));
          raise(i, a, b);
        end
      end
      rr = ($urandom_range(3) != 0);
      step();
    end

    rr = 1'b1;
    repeat (NUM_REQ + 3) step();
    chk("drain_queue", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
